// File: rtl/arm_ctrl_pkg.sv
// rtl/arm_ctrl_pkg.sv - shared run-state encoding and signature defaults for the ARM run controller
package arm_ctrl_pkg;

  // Encoding is visible on the run_state LEDs, so the values are fixed
  typedef enum logic [2:0] {
    IDLE         = 3'd0,
    RESET_HOLD   = 3'd1,
    RUN          = 3'd2,
    STEP         = 3'd3,
    DONE_PASS    = 3'd4,
    DONE_TIMEOUT = 3'd5
  } run_state_e;

  // Default pass signature written by the test program
  localparam logic [31:0] DEF_PASS_DATA  = 32'h0000_0007;
  localparam logic [31:0] DEF_PASS_ADDR1 = 32'h0000_0014;
  localparam logic [31:0] DEF_PASS_ADDR2 = 32'h0000_001A;

  // True when a write matches one signature address/data pair
  function automatic logic sig_match(
    input logic        we,
    input logic [31:0] addr,
    input logic [31:0] data,
    input logic [31:0] ref_addr,
    input logic [31:0] ref_data
  );
    return we && (addr == ref_addr) && (data == ref_data);
  endfunction

endpackage

// File: rtl/btn_sync_edge.sv
// rtl/btn_sync_edge.sv - two-flop synchronizer followed by a registered rising-edge pulse
module btn_sync_edge (
  input  logic clk,
  input  logic reset,
  input  logic i_btn,
  output logic o_pulse
);

  logic r_sync1;
  logic r_sync2;
  logic r_prev;
  logic r_pulse;

  // Bring the raw button into the clk domain and emit one pulse per rising edge
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_prev  <= 1'b0;
      r_pulse <= 1'b0;
    end else begin
      r_sync1 <= i_btn;
      r_sync2 <= r_sync1;
      r_prev  <= r_sync2;
      r_pulse <= r_sync2 & ~r_prev;
    end
  end

  assign o_pulse = r_pulse;

endmodule

// File: rtl/arm_run_ctrl.sv
// rtl/arm_run_ctrl.sv - run/step sequencer producing the gated clock enable and reset for the ARM core
module arm_run_ctrl
  import arm_ctrl_pkg::*;
#(
  parameter int          DIV_W      = 21,
  parameter int          RST_TICKS  = 2,
  parameter int          MAX_CYCLES = 1000,
  parameter logic [31:0] PASS_DATA  = DEF_PASS_DATA,
  parameter logic [31:0] PASS_ADDR1 = DEF_PASS_ADDR1,
  parameter logic [31:0] PASS_ADDR2 = DEF_PASS_ADDR2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_start_btn,
  input  logic        i_step_btn,
  input  logic        i_step_mode,
  input  logic        i_mem_we,
  input  logic [31:0] i_mem_addr,
  input  logic [31:0] i_mem_wdata,
  output logic        o_cpu_clk_en,
  output logic        o_cpu_reset,
  output logic [2:0]  o_run_state,
  output logic        o_hit1,
  output logic        o_hit2,
  output logic        o_pass,
  output logic        o_timeout,
  output logic [31:0] o_cycle_count
);

  localparam logic [31:0] MAX_CNT   = 32'(MAX_CYCLES);
  localparam logic [15:0] RST_LOAD  = 16'(RST_TICKS);
  localparam logic [31:0] CNT_SAT   = 32'hFFFF_FFFF;

  logic w_start_pulse;
  logic w_step_pulse;
  logic w_tick;
  logic w_en;
  logic w_hit1_next;
  logic w_hit2_next;
  logic w_pass_now;
  logic w_timeout_now;
  logic [31:0] w_count_inc;

  logic [DIV_W-1:0] r_div;
  run_state_e       r_state;
  logic [15:0]      r_rst_cnt;
  logic             r_step_pend;
  logic             r_cpu_reset;
  logic             r_pass;
  logic             r_timeout;
  logic             r_hit1;
  logic             r_hit2;
  logic [31:0]      r_cycle_count;

  btn_sync_edge u_start_sync (
    .clk     (clk),
    .reset   (reset),
    .i_btn   (i_start_btn),
    .o_pulse (w_start_pulse)
  );

  btn_sync_edge u_step_sync (
    .clk     (clk),
    .reset   (reset),
    .i_btn   (i_step_btn),
    .o_pulse (w_step_pulse)
  );

  // Free-running prescaler; the all-ones cycle is the CPU tick
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_div <= '0;
    end else begin
      r_div <= r_div + DIV_W'(1);
    end
  end

  assign w_tick = &r_div;

  // Enable is an AND-OR of flops only, so it is stable well before the next clk edge
  assign w_en = ((r_state == RUN) & w_tick) | ((r_state == STEP) & r_step_pend);

  // A flag set on this very enable still counts toward pass on the same cycle
  assign w_hit1_next = r_hit1 | (w_en & sig_match(i_mem_we, i_mem_addr, i_mem_wdata, PASS_ADDR1, PASS_DATA));
  assign w_hit2_next = r_hit2 | (w_en & sig_match(i_mem_we, i_mem_addr, i_mem_wdata, PASS_ADDR2, PASS_DATA));
  assign w_pass_now  = w_en & w_hit1_next & w_hit2_next;

  assign w_count_inc   = (r_cycle_count == CNT_SAT) ? r_cycle_count : r_cycle_count + 32'd1;
  assign w_timeout_now = w_en & (w_count_inc == MAX_CNT) & ~w_pass_now;

  // Signature flags and cycle counter: cleared by a fresh start, advanced by each enable
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_hit1        <= 1'b0;
      r_hit2        <= 1'b0;
      r_cycle_count <= '0;
    end else if ((r_state == IDLE) && w_start_pulse) begin
      r_hit1        <= 1'b0;
      r_hit2        <= 1'b0;
      r_cycle_count <= '0;
    end else if (w_en) begin
      r_hit1        <= w_hit1_next;
      r_hit2        <= w_hit2_next;
      r_cycle_count <= w_count_inc;
    end
  end

  // Run-state machine with its registered status outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= IDLE;
      r_rst_cnt   <= '0;
      r_step_pend <= 1'b0;
      r_cpu_reset <= 1'b1;
      r_pass      <= 1'b0;
      r_timeout   <= 1'b0;
    end else begin
      // One pending step at a time; a pulse landing while pending is dropped
      r_step_pend <= (r_state == STEP) && !w_start_pulse && !r_step_pend && w_step_pulse;

      case (r_state)
        IDLE: begin
          r_cpu_reset <= 1'b1;
          if (w_start_pulse) begin
            r_state   <= RESET_HOLD;
            r_rst_cnt <= RST_LOAD;
          end
        end

        RESET_HOLD: begin
          if (w_tick) begin
            if (r_rst_cnt <= 16'd1) begin
              r_state     <= i_step_mode ? STEP : RUN;
              r_rst_cnt   <= '0;
              r_cpu_reset <= 1'b0;
            end else begin
              r_rst_cnt <= r_rst_cnt - 16'd1;
            end
          end
        end

        RUN, STEP: begin
          if (w_start_pulse) begin
            r_state     <= IDLE;
            r_cpu_reset <= 1'b1;
          end else if (w_pass_now) begin
            r_state <= DONE_PASS;
            r_pass  <= 1'b1;
          end else if (w_timeout_now) begin
            r_state   <= DONE_TIMEOUT;
            r_timeout <= 1'b1;
          end
        end

        DONE_PASS, DONE_TIMEOUT: begin
          if (w_start_pulse) begin
            r_state     <= IDLE;
            r_cpu_reset <= 1'b1;
            r_pass      <= 1'b0;
            r_timeout   <= 1'b0;
          end
        end

        default: begin
          r_state     <= IDLE;
          r_cpu_reset <= 1'b1;
          r_pass      <= 1'b0;
          r_timeout   <= 1'b0;
        end
      endcase
    end
  end

  assign o_cpu_clk_en  = w_en;
  assign o_cpu_reset   = r_cpu_reset;
  assign o_run_state   = r_state;
  assign o_hit1        = r_hit1;
  assign o_hit2        = r_hit2;
  assign o_pass        = r_pass;
  assign o_timeout     = r_timeout;
  assign o_cycle_count = r_cycle_count;

endmodule

// File: tb/tb_arm_run_ctrl.sv
// tb/tb_arm_run_ctrl.sv - self-checking bench for arm_run_ctrl against a cycle model of the run rules
module tb_arm_run_ctrl;

  localparam int DIV_W   = 2;
  localparam int RST_T   = 2;
  localparam int MAX_C   = 10;
  localparam int PH_LAST = (1 << DIV_W) - 1;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start_btn = 1'b0;
  logic        step_btn = 1'b0;
  logic        step_mode = 1'b0;
  logic        mem_we = 1'b0;
  logic [31:0] mem_addr = '0;
  logic [31:0] mem_wdata = '0;
  logic        cpu_clk_en;
  logic        cpu_reset;
  logic [2:0]  run_state;
  logic        hit1;
  logic        hit2;
  logic        pass;
  logic        timeout;
  logic [31:0] cycle_count;

  arm_run_ctrl #(
    .DIV_W      (DIV_W),
    .RST_TICKS  (RST_T),
    .MAX_CYCLES (MAX_C)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .i_start_btn   (start_btn),
    .i_step_btn    (step_btn),
    .i_step_mode   (step_mode),
    .i_mem_we      (mem_we),
    .i_mem_addr    (mem_addr),
    .i_mem_wdata   (mem_wdata),
    .o_cpu_clk_en  (cpu_clk_en),
    .o_cpu_reset   (cpu_reset),
    .o_run_state   (run_state),
    .o_hit1        (hit1),
    .o_hit2        (hit2),
    .o_pass        (pass),
    .o_timeout     (timeout),
    .o_cycle_count (cycle_count)
  );

  always #5 clk = ~clk;

  // Model: state numbers are the documented LED encoding, time advances per clk
  typedef struct {
    int       phase;
    int       state;
    int       rst_left;
    bit       pend;
    bit       h1;
    bit       h2;
    longint   count;
    bit [3:0] sh;
    bit [3:0] th;
  } model_t;

  model_t m;

  function automatic model_t model_reset();
    model_t r;
    r.phase = 0; r.state = 0; r.rst_left = 0; r.pend = 0;
    r.h1 = 0; r.h2 = 0; r.count = 0; r.sh = '0; r.th = '0;
    return r;
  endfunction

  function automatic bit model_en(input model_t c);
    return (c.state == 2 && c.phase == PH_LAST) || (c.state == 3 && c.pend);
  endfunction

  function automatic model_t model_next(input model_t c, input bit sb, input bit tb,
                                        input bit smode, input bit we,
                                        input logic [31:0] a, input logic [31:0] d);
    model_t n = c;
    bit en   = model_en(c);
    bit sp   = c.sh[2] & ~c.sh[3];
    bit tp   = c.th[2] & ~c.th[3];
    bit tick = (c.phase == PH_LAST);
    bit pass_now;
    n.sh = {c.sh[2:0], sb};
    n.th = {c.th[2:0], tb};
    n.phase = (c.phase + 1) % (1 << DIV_W);
    if (en) begin
      if (we && a == 32'h14 && d == 32'h7) n.h1 = 1;
      if (we && a == 32'h1A && d == 32'h7) n.h2 = 1;
      if (c.count < 64'hFFFF_FFFF) n.count = c.count + 1;
    end
    pass_now = en && n.h1 && n.h2;
    n.pend = (c.state == 3) && !sp && !c.pend && tp;
    case (c.state)
      0: if (sp) begin
        n.state = 1; n.rst_left = RST_T; n.h1 = 0; n.h2 = 0; n.count = 0;
      end
      1: if (tick) begin
        if (c.rst_left <= 1) n.state = smode ? 3 : 2;
        else n.rst_left = c.rst_left - 1;
      end
      2, 3: begin
        if (sp) n.state = 0;
        else if (pass_now) n.state = 4;
        else if (en && n.count == MAX_C) n.state = 5;
      end
      4, 5: if (sp) n.state = 0;
      default: n.state = 0;
    endcase
    return n;
  endfunction

  // Model advances on the same edges as the controller
  always @(posedge clk or posedge reset) begin
    if (reset) m <= model_reset();
    else m <= model_next(m, start_btn, step_btn, step_mode, mem_we, mem_addr, mem_wdata);
  end

  int n_tests = 0;
  int n_fail = 0;
  int n_prints = 0;
  int cyc = 0;
  int prev_rs = 0;
  int hold_t0 = 0;
  int hold_len = -1;
  int last_en = -1;
  int en_gap = -1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Every wait goes through here, so the model compare runs on every cycle
  task automatic tick();
    bit e_en, e_rst, e_pass, e_to;
    @(negedge clk);
    cyc++;
    e_en = model_en(m);
    e_rst = (m.state <= 1);
    e_pass = (m.state == 4);
    e_to = (m.state == 5);
    n_tests++;
    if (cpu_clk_en !== e_en || cpu_reset !== e_rst || run_state !== 3'(m.state) ||
        hit1 !== m.h1 || hit2 !== m.h2 || pass !== e_pass || timeout !== e_to ||
        cycle_count !== 32'(m.count)) begin
      n_fail++;
      if (n_prints < 20) begin
        n_prints++;
        $display("FAIL model cyc %0d got en%b rst%b st%0d h%b%b p%b t%b cnt%0d want en%b rst%b st%0d h%b%b p%b t%b cnt%0d",
                 cyc, cpu_clk_en, cpu_reset, run_state, hit1, hit2, pass, timeout, cycle_count,
                 e_en, e_rst, m.state, m.h1, m.h2, e_pass, e_to, m.count);
      end
    end
    if (run_state == 3'd1 && prev_rs != 1) hold_t0 = cyc;
    if (prev_rs == 1 && run_state == 3'd2) hold_len = cyc - hold_t0;
    if (cpu_clk_en) begin
      if (last_en >= 0) en_gap = cyc - last_en;
      last_en = cyc;
    end
    prev_rs = int'(run_state);
  endtask

  task automatic press(input bit is_start);
    int guard = 0;
    while (m.phase != 0 && guard < 16) begin
      tick();
      guard++;
    end
    if (is_start) start_btn = 1'b1; else step_btn = 1'b1;
    repeat (4) tick();
    start_btn = 1'b0;
    step_btn = 1'b0;
    repeat (3) tick();
  endtask

  task automatic wait_en_count(input int n);
    int guard = 0;
    while (!(model_en(m) && m.count == n - 1) && guard < 400) begin
      tick();
      guard++;
    end
    if (guard >= 400) begin
      n_tests++;
      n_fail++;
      $display("FAIL wait_en_%0d: got timeout want enable", n);
    end
  endtask

  task automatic write_on_en(input int n, input logic [31:0] a, input logic [31:0] d);
    wait_en_count(n);
    mem_we = 1'b1;
    mem_addr = a;
    mem_wdata = d;
    tick();
    mem_we = 1'b0;
    mem_addr = '0;
    mem_wdata = '0;
  endtask

  initial begin
    #1 reset = 1'b1;
    repeat (3) tick();
    check("rst_cpu_reset", 32'(cpu_reset), 32'd1);
    check("rst_state", 32'(run_state), 32'd0);
    check("rst_en", 32'(cpu_clk_en), 32'd0);
    check("rst_count", cycle_count, 32'd0);
    reset = 1'b0;
    tick();

    // Free run, forward signature order
    press(1'b1);
    write_on_en(3, 32'h14, 32'h7);
    check("hold_len", 32'(hold_len), 32'd8);
    check("en_gap", 32'(en_gap), 32'd4);
    check("fwd_hit1_first", {30'd0, hit1, hit2}, 32'b10);
    write_on_en(6, 32'h1A, 32'h7);
    check("fwd_pass", 32'(pass), 32'd1);
    check("fwd_count", cycle_count, 32'd6);
    repeat (12) tick();
    check("fwd_count_frozen", cycle_count, 32'd6);

    // Abort from DONE keeps flags; reverse order run
    press(1'b1);
    check("abort_state", 32'(run_state), 32'd0);
    check("abort_keeps_hit1", 32'(hit1), 32'd1);
    press(1'b1);
    write_on_en(2, 32'h1A, 32'h7);
    check("rev_hit2_first", {30'd0, hit1, hit2}, 32'b01);
    write_on_en(4, 32'h14, 32'h7);
    check("rev_pass", 32'(pass), 32'd1);
    check("rev_count", cycle_count, 32'd4);

    // Wrong data on second address, runs to timeout
    press(1'b1);
    press(1'b1);
    write_on_en(2, 32'h1A, 32'h6);
    write_on_en(4, 32'h14, 32'h7);
    wait_en_count(10);
    tick();
    check("to_timeout", 32'(timeout), 32'd1);
    check("to_pass", 32'(pass), 32'd0);
    check("to_count", cycle_count, 32'd10);

    // Pass completes on the last allowed enable: pass wins
    press(1'b1);
    press(1'b1);
    write_on_en(3, 32'h14, 32'h7);
    write_on_en(10, 32'h1A, 32'h7);
    check("edge_pass", 32'(pass), 32'd1);
    check("edge_timeout", 32'(timeout), 32'd0);
    check("edge_count", cycle_count, 32'd10);

    // Single step
    press(1'b1);
    step_mode = 1'b1;
    press(1'b1);
    repeat (30) tick();
    check("step_idle_state", 32'(run_state), 32'd3);
    check("step_idle_count", cycle_count, 32'd0);
    for (int i = 0; i < 3; i++) press(1'b0);
    repeat (5) tick();
    check("step_count", cycle_count, 32'd3);

    // Abort during RUN
    press(1'b1);
    step_mode = 1'b0;
    press(1'b1);
    wait_en_count(2);
    press(1'b1);
    check("run_abort_state", 32'(run_state), 32'd0);
    check("run_abort_cpu_reset", 32'(cpu_reset), 32'd1);

    // Asynchronous reset in the middle of a clk period
    press(1'b1);
    wait_en_count(3);
    #2 reset = 1'b1;
    #1;
    check("arst_en", 32'(cpu_clk_en), 32'd0);
    check("arst_cpu_reset", 32'(cpu_reset), 32'd1);
    check("arst_state", 32'(run_state), 32'd0);
    check("arst_flags", {28'd0, hit1, hit2, pass, timeout}, 32'd0);
    check("arst_count", cycle_count, 32'd0);
    tick();
    reset = 1'b0;
    repeat (4) tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
